// File: rtl/memory_access.sv
// Pipeline memory stage: issues one data-bus transaction per load/store and hands
// results, misalignment faults or bus timeouts to writeback as single-cycle pulses.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] pcsrc_i,
    input  logic [31:0] offset_i,
    input  logic [1:0]  mem_to_reg_i,
    input  logic [4:0]  rd_i,
    input  logic        reg_write_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        wb_valid_o,
    output logic [31:0] data_read_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] pcsrc_o,
    output logic [31:0] offset_o,
    output logic [1:0]  mem_to_reg_o,
    output logic [4:0]  rd_o,
    output logic        reg_write_o,
    output logic        misaligned_o,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  boff_q, boff_d;

    logic [31:0] p_alu_q, p_alu_d;
    logic [31:0] p_pcsrc_q, p_pcsrc_d;
    logic [31:0] p_offset_q, p_offset_d;
    logic [1:0]  p_m2r_q, p_m2r_d;
    logic [4:0]  p_rd_q, p_rd_d;
    logic        p_rw_q, p_rw_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] alu_o_q, alu_o_d;
    logic [31:0] pcsrc_o_q, pcsrc_o_d;
    logic [31:0] offset_o_q, offset_o_d;
    logic [1:0]  m2r_o_q, m2r_o_d;
    logic [4:0]  rd_o_q, rd_o_d;
    logic        rw_o_q, rw_o_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;

    logic        legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Width/alignment legality and store lane steering, decoded from the incoming instruction.
    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~alu_result_i[0];
            3'b010:         legal = (alu_result_i[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase

        st_be    = 4'b1111;
        st_wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_i[1:0];
                st_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {alu_result_i[1], 1'b0};
                st_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data_i;
            end
        endcase
    end

    // Load data is shifted down to the addressed lane, then sign/zero extended.
    always_comb begin
        lane = dmem_rdata_i >> {boff_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'b0, lane[7:0]};
            3'b101:  load_data = {16'b0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        funct3_d   = funct3_q;
        boff_d     = boff_q;
        p_alu_d    = p_alu_q;
        p_pcsrc_d  = p_pcsrc_q;
        p_offset_d = p_offset_q;
        p_m2r_d    = p_m2r_q;
        p_rd_d     = p_rd_q;
        p_rw_d     = p_rw_q;
        wb_valid_d = 1'b0;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        data_d     = data_q;
        alu_o_d    = alu_o_q;
        pcsrc_o_d  = pcsrc_o_q;
        offset_o_d = offset_o_q;
        m2r_o_d    = m2r_o_q;
        rd_o_d     = rd_o_q;
        rw_o_d     = rw_o_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if ((mem_read_i || mem_write_i) && legal) begin
                        state_d    = BUSY;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        we_d       = mem_write_i;
                        addr_d     = {alu_result_i[31:2], 2'b00};
                        wdata_d    = mem_write_i ? st_wdata : 32'h0;
                        be_d       = mem_write_i ? st_be : 4'b1111;
                        funct3_d   = funct3_i;
                        boff_d     = alu_result_i[1:0];
                        p_alu_d    = alu_result_i;
                        p_pcsrc_d  = pcsrc_i;
                        p_offset_d = offset_i;
                        p_m2r_d    = mem_to_reg_i;
                        p_rd_d     = rd_i;
                        p_rw_d     = reg_write_i;
                    end else begin
                        // Plain ALU ops and illegal accesses both retire one cycle later.
                        wb_valid_d = 1'b1;
                        mis_d      = mem_read_i || mem_write_i;
                        data_d     = 32'h0;
                        alu_o_d    = alu_result_i;
                        pcsrc_o_d  = pcsrc_i;
                        offset_o_d = offset_i;
                        m2r_o_d    = mem_to_reg_i;
                        rd_o_d     = rd_i;
                        rw_o_d     = reg_write_i && !(mem_read_i || mem_write_i);
                    end
                end
            end
            BUSY: begin
                if (dmem_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    berr_d     = !dmem_ack_i;
                    data_d     = (dmem_ack_i && !we_q) ? load_data : 32'h0;
                    alu_o_d    = p_alu_q;
                    pcsrc_o_d  = p_pcsrc_q;
                    offset_o_d = p_offset_q;
                    m2r_o_d    = p_m2r_q;
                    rd_o_d     = p_rd_q;
                    rw_o_d     = p_rw_q && dmem_ack_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            funct3_q   <= 3'h0;
            boff_q     <= 2'h0;
            p_alu_q    <= 32'h0;
            p_pcsrc_q  <= 32'h0;
            p_offset_q <= 32'h0;
            p_m2r_q    <= 2'h0;
            p_rd_q     <= 5'h0;
            p_rw_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            data_q     <= 32'h0;
            alu_o_q    <= 32'h0;
            pcsrc_o_q  <= 32'h0;
            offset_o_q <= 32'h0;
            m2r_o_q    <= 2'h0;
            rd_o_q     <= 5'h0;
            rw_o_q     <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            funct3_q   <= funct3_d;
            boff_q     <= boff_d;
            p_alu_q    <= p_alu_d;
            p_pcsrc_q  <= p_pcsrc_d;
            p_offset_q <= p_offset_d;
            p_m2r_q    <= p_m2r_d;
            p_rd_q     <= p_rd_d;
            p_rw_q     <= p_rw_d;
            wb_valid_q <= wb_valid_d;
            data_q     <= data_d;
            alu_o_q    <= alu_o_d;
            pcsrc_o_q  <= pcsrc_o_d;
            offset_o_q <= offset_o_d;
            m2r_o_q    <= m2r_o_d;
            rd_o_q     <= rd_o_d;
            rw_o_q     <= rw_o_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
        end
    end

    assign stall_o      = (state_q == BUSY);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_valid_o   = wb_valid_q;
    assign data_read_o  = data_q;
    assign alu_result_o = alu_o_q;
    assign pcsrc_o      = pcsrc_o_q;
    assign offset_o     = offset_o_q;
    assign mem_to_reg_o = m2r_o_q;
    assign rd_o         = rd_o_q;
    assign reg_write_o  = rw_o_q;
    assign misaligned_o = mis_q;
    assign bus_err_o    = berr_q;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: a byte-level memory model predicts writeback
// results and bus requests; a bus-slave process answers with randomized latency.
module tb_memory_access;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [2:0]  funct3_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] pcsrc_i;
    logic [31:0] offset_i;
    logic [1:0]  mem_to_reg_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        wb_valid_o;
    logic [31:0] data_read_o;
    logic [31:0] alu_result_o;
    logic [31:0] pcsrc_o;
    logic [31:0] offset_o;
    logic [1:0]  mem_to_reg_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;
    logic        misaligned_o;
    logic        bus_err_o;

    memory_access #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .funct3_i(funct3_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .pcsrc_i(pcsrc_i),
        .offset_i(offset_i), .mem_to_reg_i(mem_to_reg_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_be_o(dmem_be_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .wb_valid_o(wb_valid_o), .data_read_o(data_read_o), .alu_result_o(alu_result_o),
        .pcsrc_o(pcsrc_o), .offset_o(offset_o), .mem_to_reg_o(mem_to_reg_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .misaligned_o(misaligned_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dataRead, aluResult, pcsrc, offset;
        logic [1:0]  memToReg;
        logic [4:0]  rd;
        logic        regWrite, misaligned, busErr;
    } wbExp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic        we;
        logic [3:0]  be;
    } busExp_t;

    typedef struct {
        logic [31:0] alu, sdata, pcsrc, offset;
        logic [2:0]  f3;
        logic        memRead, memWrite, rw;
        logic [1:0]  m2r;
        logic [4:0]  rd;
    } instr_t;

    wbExp_t      wbQ[$];
    busExp_t     busQ[$];
    int          latQ[$];
    logic [7:0]  refMem [1024];
    logic [31:0] slaveMem [256];
    int          assertCount = 0;
    int          failCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int accessSize(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic instr_t mkInstr(input logic [2:0] f3, input logic rdFlag, input logic wrFlag,
                                       input logic [31:0] alu, input logic [31:0] sdata);
        instr_t ins;
        ins.f3 = f3; ins.memRead = rdFlag; ins.memWrite = wrFlag;
        ins.alu = alu; ins.sdata = sdata;
        ins.pcsrc = $urandom; ins.offset = $urandom;
        ins.m2r = 2'($urandom_range(0, 3)); ins.rd = 5'($urandom_range(0, 31));
        ins.rw = 1'($urandom_range(0, 1));
        return ins;
    endfunction

    task automatic setWord(input int addr, input logic [31:0] val);
        for (int k = 0; k < 4; k++) refMem[addr + k] = 8'(val >> (8 * k));
        slaveMem[addr / 4] = val;
    endtask

    // Drives one instruction and predicts its writeback and bus request from the memory model.
    task automatic issueInstr(input instr_t ins, input int lat, output int expStall);
        wbExp_t  e;
        busExp_t b;
        int size, a, beInt;
        logic [31:0] val;
        valid_i = 1'b1; alu_result_i = ins.alu; store_data_i = ins.sdata; funct3_i = ins.f3;
        mem_read_i = ins.memRead; mem_write_i = ins.memWrite; pcsrc_i = ins.pcsrc;
        offset_i = ins.offset; mem_to_reg_i = ins.m2r; rd_i = ins.rd; reg_write_i = ins.rw;
        e.dataRead = 32'h0; e.aluResult = ins.alu; e.pcsrc = ins.pcsrc; e.offset = ins.offset;
        e.memToReg = ins.m2r; e.rd = ins.rd; e.regWrite = ins.rw;
        e.misaligned = 1'b0; e.busErr = 1'b0;
        expStall = 0;
        if (ins.memRead || ins.memWrite) begin
            size = accessSize(ins.f3);
            a = int'(ins.alu[9:0]);
            if (size == 0 || (a % size) != 0) begin
                e.misaligned = 1'b1;
                e.regWrite = 1'b0;
            end else begin
                b.addr = ins.alu - (ins.alu % 4);
                b.we = ins.memWrite;
                beInt = ((1 << size) - 1) << (a % 4);
                b.be = ins.memWrite ? 4'(beInt) : 4'hF;
                if (size == 1) b.wdata = (ins.sdata & 32'hFF) * 32'h0101_0101;
                else if (size == 2) b.wdata = (ins.sdata & 32'hFFFF) * 32'h0001_0001;
                else b.wdata = ins.sdata;
                busQ.push_back(b);
                latQ.push_back(lat);
                expStall = (lat > TIMEOUT) ? TIMEOUT : lat;
                if (lat > TIMEOUT) begin
                    e.busErr = 1'b1;
                    e.regWrite = 1'b0;
                end else if (ins.memWrite) begin
                    for (int k = 0; k < size; k++) refMem[a + k] = 8'(ins.sdata >> (8 * k));
                end else begin
                    val = 32'h0;
                    for (int k = 0; k < size; k++) val = val + (32'(refMem[a + k]) << (8 * k));
                    if (ins.f3 == 3'd0 && val >= 32'd128) val = val - 32'd256;
                    if (ins.f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
                    e.dataRead = val;
                end
            end
        end
        wbQ.push_back(e);
    endtask

    task automatic driveJunk();
        valid_i = 1'($urandom_range(0, 1)); alu_result_i = $urandom; store_data_i = $urandom;
        funct3_i = 3'($urandom_range(0, 7)); mem_read_i = 1'($urandom_range(0, 1));
        mem_write_i = 1'($urandom_range(0, 1)); reg_write_i = 1'($urandom_range(0, 1));
    endtask

    task automatic waitComplete(input int expStall, input string tag);
        int cnt = 0;
        @(negedge clk_i);
        valid_i = 1'b0;
        while (stall_o && cnt < 40) begin
            cnt++;
            driveJunk();
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        checkOutput({tag, "_stall_cycles"}, 32'(cnt), 32'(expStall));
    endtask

    task automatic applyStimulus(input instr_t ins, input int lat, input string tag);
        int es;
        issueInstr(ins, lat, es);
        waitComplete(es, tag);
    endtask

    // Writeback monitor: every wb pulse must match the oldest prediction.
    initial begin
        wbExp_t e;
        forever begin
            @(negedge clk_i);
            if (reset_i === 1'b1) begin
                if (wb_valid_o) begin
                    if (wbQ.size() == 0) begin
                        assertCount++; failCount++;
                        $display("[TB] FAIL unexpected_wb: got wb_valid_o=1, expected no pending result at %0t", $time);
                    end else begin
                        e = wbQ.pop_front();
                        checkOutput("wb_data_read", data_read_o, e.dataRead);
                        checkOutput("wb_alu_result", alu_result_o, e.aluResult);
                        checkOutput("wb_pcsrc", pcsrc_o, e.pcsrc);
                        checkOutput("wb_offset", offset_o, e.offset);
                        checkOutput("wb_mem_to_reg", 32'(mem_to_reg_o), 32'(e.memToReg));
                        checkOutput("wb_rd", 32'(rd_o), 32'(e.rd));
                        checkOutput("wb_reg_write", 32'(reg_write_o), 32'(e.regWrite));
                        checkOutput("wb_misaligned", 32'(misaligned_o), 32'(e.misaligned));
                        checkOutput("wb_bus_err", 32'(bus_err_o), 32'(e.busErr));
                    end
                end else begin
                    checkOutput("stray_fault", {30'b0, misaligned_o, bus_err_o}, 32'h0);
                end
            end
        end
    end

    // Bus slave: checks each request cycle against the prediction and acks after the chosen latency.
    initial begin
        busExp_t cur;
        int reqCount = 0;
        int curLat = 0;
        int idx;
        dmem_ack_i = 1'b0;
        dmem_rdata_i = 32'h0;
        cur.addr = 32'h0; cur.wdata = 32'h0; cur.we = 1'b0; cur.be = 4'h0;
        forever begin
            @(negedge clk_i);
            if (reset_i === 1'b1 && dmem_req_o) begin
                if (reqCount == 0) begin
                    if (busQ.size() == 0 || latQ.size() == 0) begin
                        assertCount++; failCount++;
                        $display("[TB] FAIL unexpected_req: got dmem_req_o=1 addr 0x%08h, expected no request", dmem_addr_o);
                        curLat = 0;
                    end else begin
                        cur = busQ.pop_front();
                        curLat = latQ.pop_front();
                    end
                end
                reqCount++;
                checkOutput("bus_addr", dmem_addr_o, cur.addr);
                checkOutput("bus_we", 32'(dmem_we_o), 32'(cur.we));
                checkOutput("bus_be", 32'(dmem_be_o), 32'(cur.be));
                if (cur.we) checkOutput("bus_wdata", dmem_wdata_o, cur.wdata);
                idx = int'(dmem_addr_o[9:2]);
                if (reqCount == curLat) begin
                    dmem_ack_i = 1'b1;
                    if (dmem_we_o) begin
                        dmem_rdata_i = $urandom;
                        for (int k = 0; k < 4; k++)
                            if (dmem_be_o[k]) slaveMem[idx][8*k +: 8] = dmem_wdata_o[8*k +: 8];
                    end else begin
                        dmem_rdata_i = slaveMem[idx];
                    end
                end else begin
                    dmem_ack_i = 1'b0;
                    dmem_rdata_i = $urandom;
                end
            end else begin
                reqCount = 0;
                dmem_ack_i = ($urandom_range(0, 3) == 0);
                dmem_rdata_i = $urandom;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        instr_t ins;
        int es, r, lat;
        logic [31:0] alu;
        logic [2:0] f3;
        const logic [2:0] legalF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        const logic [2:0] badF3 [3] = '{3'd3, 3'd6, 3'd7};

        for (int i = 0; i < 1024; i++) refMem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++)
            slaveMem[i] = {refMem[4*i+3], refMem[4*i+2], refMem[4*i+1], refMem[4*i]};

        reset_i = 1'b0; valid_i = 1'b0; alu_result_i = 32'h0; store_data_i = 32'h0;
        funct3_i = 3'h0; mem_read_i = 1'b0; mem_write_i = 1'b0; pcsrc_i = 32'h0;
        offset_i = 32'h0; mem_to_reg_i = 2'h0; rd_i = 5'h0; reg_write_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_stall", 32'(stall_o), 32'h0);
        checkOutput("rst_req", 32'(dmem_req_o), 32'h0);
        checkOutput("rst_be", 32'(dmem_be_o), 32'h0);
        checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'h0);
        checkOutput("rst_data_read", data_read_o, 32'h0);
        checkOutput("rst_reg_write", 32'(reg_write_o), 32'h0);
        checkOutput("rst_faults", {30'b0, misaligned_o, bus_err_o}, 32'h0);
        reset_i = 1'b1;

        $display("[TB] directed cases");
        applyStimulus(mkInstr(3'd0, 1'b0, 1'b0, 32'h1234_5677, 32'h0), 1, "alu_pass");
        setWord(32'h100, 32'hDEAD_BEEF);
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b0, 32'h100, 32'h0), 3, "lw_lat3");
        setWord(32'h100, 32'h80FF_0000);
        applyStimulus(mkInstr(3'd0, 1'b1, 1'b0, 32'h103, 32'h0), 2, "lb_sext");
        applyStimulus(mkInstr(3'd4, 1'b1, 1'b0, 32'h103, 32'h0), 1, "lbu_zext");
        applyStimulus(mkInstr(3'd1, 1'b0, 1'b1, 32'h202, 32'h1234_ABCD), 2, "sh_upper");
        applyStimulus(mkInstr(3'd5, 1'b1, 1'b0, 32'h202, 32'h0), 1, "lhu_after_sh");
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b1, 32'h204, 32'hCAFE_F00D), 1, "rw_is_store");
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b0, 32'h101, 32'h0), 1, "lw_misaligned");
        applyStimulus(mkInstr(3'd6, 1'b1, 1'b0, 32'h100, 32'h0), 1, "bad_funct3");
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b0, 32'h104, 32'h0), TIMEOUT + 1, "lw_timeout");
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b0, 32'h104, 32'h0), TIMEOUT, "lw_ack_last");

        $display("[TB] reset during busy");
        issueInstr(mkInstr(3'd2, 1'b1, 1'b0, 32'h200, 32'h0), 100, es);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("busy_before_reset", 32'(dmem_req_o), 32'h1);
        #2 reset_i = 1'b0;
        #1;
        checkOutput("reset_drops_req", 32'(dmem_req_o), 32'h0);
        checkOutput("reset_drops_stall", 32'(stall_o), 32'h0);
        checkOutput("reset_wb_valid", 32'(wb_valid_o), 32'h0);
        wbQ.delete(); busQ.delete(); latQ.delete();
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("post_reset_wb", 32'(wb_valid_o), 32'h0);
        end
        applyStimulus(mkInstr(3'd2, 1'b1, 1'b0, 32'h300, 32'h0), 1, "first_after_reset");

        $display("[TB] random cases");
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
            r = $urandom_range(0, 9);
            f3 = (r == 0) ? badF3[$urandom_range(0, 2)] : legalF3[$urandom_range(0, 4)];
            alu = $urandom;
            r = $urandom_range(0, 3);
            if (r == 1) alu = alu & 32'hFFFF_FFFE;
            if (r == 2) alu = alu & 32'hFFFF_FFFC;
            r = $urandom_range(0, 7);
            ins = mkInstr(f3, (r >= 2 && r <= 4) || r == 7, r >= 5, alu, $urandom);
            lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(1, 6);
            applyStimulus(ins, lat, "rnd");
        end

        repeat (3) @(negedge clk_i);
        checkOutput("wbq_drained", 32'(wbQ.size()), 32'h0);
        checkOutput("busq_drained", 32'(busQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
